// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM latch sequencer: op codes, FSM states and
// the command record carried through the command FIFO.
package pwm_pkg;

  localparam logic [1:0] OP_DUTY   = 2'b00;
  localparam logic [1:0] OP_BCAST  = 2'b01;
  localparam logic [1:0] OP_OE_SET = 2'b10;
  localparam logic [1:0] OP_OE_CLR = 2'b11;

  // Command fields are stored at fixed widths wide enough for any supported
  // configuration (up to 256 channels, up to 16-bit duty).
  localparam int CMD_CHAN_W = 8;
  localparam int CMD_DUTY_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } state_e;

  typedef struct packed {
    logic [1:0]            op;
    logic [CMD_CHAN_W-1:0] chan;
    logic [CMD_DUTY_W-1:0] duty;
  } cmd_t;

  function automatic cmd_t make_cmd(input logic [1:0]            op,
                                    input logic [CMD_CHAN_W-1:0] chan,
                                    input logic [CMD_DUTY_W-1:0] duty);
    cmd_t c;
    c.op   = op;
    c.chan = chan;
    c.duty = duty;
    return c;
  endfunction

  // Duty and broadcast ops go through the setup/strobe/hold sequence.
  function automatic logic is_duty_op(input logic [1:0] op);
    return !op[1];
  endfunction

endpackage

// File: rtl/pwm_cmd_fifo.sv
// Synchronous command FIFO. The read side sees a write one cycle after it
// lands, so a freshly accepted command is popped no earlier than two edges
// after acceptance; full/occupied use the live pointers so back-pressure and
// the busy indication are never late.
module pwm_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             occupied_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      wr_vis_q;
  logic             do_push, do_pop;

  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign occupied_o = (wr_ptr_q != rd_ptr_q);
  assign empty_o    = (wr_vis_q == rd_ptr_q);
  assign do_pop     = pop_i && !empty_o;
  // A push into a full FIFO is accepted when the head leaves in the same cycle.
  assign do_push    = push_i && (!full_o || do_pop);
  assign head_o     = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance for accepted pushes and pops.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers; reset flushes the FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wr_vis_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_vis_q <= wr_ptr_q;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/pwm_latch_sequencer.sv
// Owns the shared Ton bus and the per-channel nLatch / oe lines of the PWM
// bank. Host commands are queued in a small FIFO and replayed one at a time;
// duty updates follow a setup / one-cycle strobe / hold sequence so the bank
// always sees a stable Ton around the latching edge.
module pwm_latch_sequencer
  import pwm_pkg::*;
#(
  parameter int NB_PWM     = 24,
  parameter int RESOLUTION = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int CHAN_W     = $clog2(NB_PWM)
) (
  input  logic                  ClkIn,
  input  logic                  Reset,
  input  logic                  CmdValid,
  output logic                  CmdReady,
  input  logic [1:0]            CmdOp,
  input  logic [CHAN_W-1:0]     CmdChan,
  input  logic [RESOLUTION-1:0] CmdDuty,
  output logic [RESOLUTION-1:0] Ton,
  output logic [NB_PWM-1:0]     nLatch,
  output logic [NB_PWM-1:0]     oe,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Err
);

  state_e                state_q, state_d;
  cmd_t                  cmd_q, cmd_d;
  cmd_t                  cmd_in, fifo_head;
  logic [RESOLUTION-1:0] ton_q, ton_d;
  logic [NB_PWM-1:0]     nlatch_q, nlatch_d;
  logic [NB_PWM-1:0]     oe_q, oe_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  fifo_push, fifo_pop;
  logic                  fifo_full, fifo_empty, fifo_occupied;
  logic                  chan_bad;
  logic [CHAN_W-1:0]     chan_idx;
  logic                  unused_cmd_bits;

  assign cmd_in    = make_cmd(CmdOp, CMD_CHAN_W'(CmdChan), CMD_DUTY_W'(CmdDuty));
  assign CmdReady  = !fifo_full;
  assign fifo_push = CmdValid && CmdReady;

  pwm_cmd_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (ClkIn),
    .rst_i      (Reset),
    .push_i     (fifo_push),
    .wdata_i    (cmd_in),
    .pop_i      (fifo_pop),
    .head_o     (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .occupied_o (fifo_occupied)
  );

  // Broadcast ignores the channel field, so it can never be out of range.
  assign chan_bad = (cmd_q.op != OP_BCAST) && (32'(cmd_q.chan) >= NB_PWM);
  assign chan_idx = cmd_q.chan[CHAN_W-1:0];

  // Duty bits above RESOLUTION are always zero-filled at the input.
  assign unused_cmd_bits = ^cmd_q.duty;

  // Sequencer next-state and next values of the bank-facing registers.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    ton_d    = ton_q;
    nlatch_d = '1;
    oe_d     = oe_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    fifo_pop = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cmd_d    = fifo_head;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (chan_bad) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (!is_duty_op(cmd_q.op)) begin
          oe_d[chan_idx] = (cmd_q.op == OP_OE_SET);
          done_d         = 1'b1;
          state_d        = ST_IDLE;
        end else begin
          ton_d   = cmd_q.duty[RESOLUTION-1:0];
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cmd_q.op == OP_BCAST) nlatch_d = '0;
        else                      nlatch_d[chan_idx] = 1'b0;
        state_d = ST_STROBE;
      end
      ST_STROBE: begin
        done_d  = 1'b1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and bank-facing registers; reset returns the bank lines to idle.
  always_ff @(posedge ClkIn) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      ton_q    <= '0;
      nlatch_q <= '1;
      oe_q     <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ton_q    <= ton_d;
      nlatch_q <= nlatch_d;
      oe_q     <= oe_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Command register holds the popped entry for the whole sequence.
  always_ff @(posedge ClkIn) begin
    cmd_q <= cmd_d;
  end

  assign Ton    = ton_q;
  assign nLatch = nlatch_q;
  assign oe     = oe_q;
  assign Done   = done_q;
  assign Err    = err_q;
  assign Busy   = fifo_occupied || (state_q != ST_IDLE);

endmodule

// File: tb/tb_pwm_latch_sequencer.sv
// Bench for pwm_latch_sequencer: reset values, cycle-exact timing of a duty
// and an oe command, a table of commands checked through a scoreboard, FIFO
// back-pressure with back-to-back duty commands, and reset mid-strobe.
module tb_pwm_latch_sequencer;
  import pwm_pkg::*;

  typedef struct packed {
    logic        err;
    logic [9:0]  ton;
    logic [23:0] nl;
    logic [23:0] oe;
  } exp_t;

  typedef struct packed {
    logic [1:0] op;
    logic [4:0] chan;
    logic [9:0] duty;
    exp_t       exp;
  } vec_t;

  typedef struct packed {
    logic [9:0]  ton;
    logic [23:0] nl;
    logic        done;
    logic        busy;
  } cyc_t;

  logic        clk = 1'b0;
  logic        Reset;
  logic        CmdValid;
  logic        CmdReady;
  logic [1:0]  CmdOp;
  logic [4:0]  CmdChan;
  logic [9:0]  CmdDuty;
  logic [9:0]  Ton;
  logic [23:0] nLatch;
  logic [23:0] oe;
  logic        Busy, Done, Err;

  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  exp_t        sb_q[$];
  exp_t        mon_e;
  bit          mon_en = 1'b1;
  bit          log_done = 1'b0;
  int          done_cyc[$];
  int          strobe_cnt = 0;
  logic [23:0] strobe_pat = '1;

  vec_t        vecs[10];
  cyc_t        tim[6];

  pwm_latch_sequencer #(
    .NB_PWM(24), .RESOLUTION(10), .FIFO_DEPTH(4), .CHAN_W(5)
  ) dut (
    .ClkIn(clk), .Reset(Reset), .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdOp(CmdOp), .CmdChan(CmdChan), .CmdDuty(CmdDuty), .Ton(Ton),
    .nLatch(nLatch), .oe(oe), .Busy(Busy), .Done(Done), .Err(Err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Scoreboard: every Done/Err pops the oldest expected completion.
  always @(negedge clk) begin
    if (Reset || !mon_en) begin
      strobe_cnt = 0;
      strobe_pat = '1;
    end else begin
      if (nLatch != 24'hFFFFFF) begin
        strobe_cnt++;
        strobe_pat = nLatch;
      end
      if (Done || Err) begin
        if (log_done && Done) done_cyc.push_back(cyc);
        if (sb_q.size() == 0) begin
          chk("unexpected_completion", 32'(Done | Err), 32'(0));
        end else begin
          mon_e = sb_q.pop_front();
          chk("sb_err", 32'(Err), 32'(mon_e.err));
          chk("sb_done", 32'(Done), 32'(!mon_e.err));
          chk("sb_ton", 32'(Ton), 32'(mon_e.ton));
          chk("sb_oe", 32'(oe), 32'(mon_e.oe));
          chk("sb_strobe_pat", 32'(strobe_pat), 32'(mon_e.nl));
          chk("sb_strobe_cycles", 32'(strobe_cnt), 32'((mon_e.nl != 24'hFFFFFF) ? 1 : 0));
        end
        strobe_cnt = 0;
        strobe_pat = '1;
      end
    end
  end

  task automatic do_reset();
    Reset = 1'b1;
    CmdValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    Reset = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send(input logic [1:0] op, input logic [4:0] ch, input logic [9:0] d);
    int w;
    CmdOp = op; CmdChan = ch; CmdDuty = d; CmdValid = 1'b1;
    w = 0;
    while (!CmdReady && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!CmdReady) chk("send_ready_timeout", 32'(0), 32'(1));
    @(negedge clk);
    CmdValid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int w;
    w = 0;
    while ((sb_q.size() != 0 || Busy) && w < bound) begin
      @(negedge clk);
      w++;
    end
    chk("idle_timeout", 32'(sb_q.size() != 0 || Busy), 32'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, idx, w, evts;
    bit saw_drop;

    vecs[0] = '{op:OP_DUTY,   chan:5'd5,  duty:10'h155, exp:'{err:1'b0, ton:10'h155, nl:24'hFFFFDF, oe:24'h000000}};
    vecs[1] = '{op:OP_BCAST,  chan:5'd0,  duty:10'h3FF, exp:'{err:1'b0, ton:10'h3FF, nl:24'h000000, oe:24'h000000}};
    vecs[2] = '{op:OP_OE_SET, chan:5'd23, duty:10'h000, exp:'{err:1'b0, ton:10'h3FF, nl:24'hFFFFFF, oe:24'h800000}};
    vecs[3] = '{op:OP_OE_CLR, chan:5'd23, duty:10'h000, exp:'{err:1'b0, ton:10'h3FF, nl:24'hFFFFFF, oe:24'h000000}};
    vecs[4] = '{op:OP_DUTY,   chan:5'd30, duty:10'h0AA, exp:'{err:1'b1, ton:10'h3FF, nl:24'hFFFFFF, oe:24'h000000}};
    vecs[5] = '{op:OP_OE_SET, chan:5'd0,  duty:10'h000, exp:'{err:1'b0, ton:10'h3FF, nl:24'hFFFFFF, oe:24'h000001}};
    vecs[6] = '{op:OP_DUTY,   chan:5'd23, duty:10'h001, exp:'{err:1'b0, ton:10'h001, nl:24'h7FFFFF, oe:24'h000001}};
    vecs[7] = '{op:OP_OE_CLR, chan:5'd31, duty:10'h000, exp:'{err:1'b1, ton:10'h001, nl:24'hFFFFFF, oe:24'h000001}};
    vecs[8] = '{op:OP_BCAST,  chan:5'd31, duty:10'h000, exp:'{err:1'b0, ton:10'h000, nl:24'h000000, oe:24'h000001}};
    vecs[9] = '{op:OP_OE_SET, chan:5'd24, duty:10'h000, exp:'{err:1'b1, ton:10'h000, nl:24'hFFFFFF, oe:24'h000001}};

    Reset = 1'b1; CmdValid = 1'b0; CmdOp = '0; CmdChan = '0; CmdDuty = '0;
    @(negedge clk);
    do_reset();

    chk("rst_ton", 32'(Ton), 32'(0));
    chk("rst_nlatch", 32'(nLatch), 32'(24'hFFFFFF));
    chk("rst_oe", 32'(oe), 32'(0));
    chk("rst_done", 32'(Done), 32'(0));
    chk("rst_err", 32'(Err), 32'(0));
    chk("rst_busy", 32'(Busy), 32'(0));
    chk("rst_ready", 32'(CmdReady), 32'(1));

    // Duty command timing, E+1 .. E+6.
    tim[0] = '{ton:10'h000, nl:24'hFFFFFF, done:1'b0, busy:1'b1};
    tim[1] = '{ton:10'h000, nl:24'hFFFFFF, done:1'b0, busy:1'b1};
    tim[2] = '{ton:10'h155, nl:24'hFFFFFF, done:1'b0, busy:1'b1};
    tim[3] = '{ton:10'h155, nl:24'hFFFFDF, done:1'b0, busy:1'b1};
    tim[4] = '{ton:10'h155, nl:24'hFFFFFF, done:1'b1, busy:1'b1};
    tim[5] = '{ton:10'h155, nl:24'hFFFFFF, done:1'b0, busy:1'b0};
    sb_q.push_back('{err:1'b0, ton:10'h155, nl:24'hFFFFDF, oe:24'h000000});
    send(OP_DUTY, 5'd5, 10'h155);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("duty_e%0d_ton", k + 1), 32'(Ton), 32'(tim[k].ton));
      chk($sformatf("duty_e%0d_nlatch", k + 1), 32'(nLatch), 32'(tim[k].nl));
      chk($sformatf("duty_e%0d_done", k + 1), 32'(Done), 32'(tim[k].done));
      chk($sformatf("duty_e%0d_busy", k + 1), 32'(Busy), 32'(tim[k].busy));
    end

    // Oe command timing: oe and Done at E+3.
    sb_q.push_back('{err:1'b0, ton:10'h155, nl:24'hFFFFFF, oe:24'h000400});
    send(OP_OE_SET, 5'd10, 10'h000);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("oe_e%0d_oe", k), 32'(oe), 32'((k >= 3) ? 24'h000400 : 24'h000000));
      chk($sformatf("oe_e%0d_done", k), 32'(Done), 32'((k == 3) ? 1 : 0));
      chk($sformatf("oe_e%0d_busy", k), 32'(Busy), 32'((k <= 2) ? 1 : 0));
    end
    wait_idle(20);

    do_reset();
    chk("rst2_oe", 32'(oe), 32'(0));
    chk("rst2_ton", 32'(Ton), 32'(0));

    // Table of commands, one at a time.
    for (int i = 0; i < 10; i++) begin
      sb_q.push_back(vecs[i].exp);
      send(vecs[i].op, vecs[i].chan, vecs[i].duty);
      wait_idle(40);
    end

    // FIFO full: six duty commands with CmdValid held.
    done_cyc.delete();
    log_done = 1'b1;
    idx = 0; acc = 0; saw_drop = 1'b0; w = 0;
    while (idx < 6 && w < 200) begin
      CmdValid = 1'b1; CmdOp = OP_DUTY; CmdChan = 5'(idx); CmdDuty = 10'(10'h100 + idx);
      if (CmdReady) begin
        sb_q.push_back('{err:1'b0, ton:10'(10'h100 + idx), nl:~(24'h1 << idx), oe:24'h000001});
        idx++;
        acc++;
      end else if (!saw_drop) begin
        saw_drop = 1'b1;
        chk("full_ready_drop_after", 32'(acc), 32'(5));
      end
      @(negedge clk);
      w++;
    end
    CmdValid = 1'b0;
    chk("full_ready_dropped", 32'(saw_drop), 32'(1));
    chk("full_all_accepted", 32'(acc), 32'(6));
    wait_idle(100);
    log_done = 1'b0;
    chk("full_done_count", 32'(done_cyc.size()), 32'(6));
    for (int i = 1; i < done_cyc.size(); i++)
      chk($sformatf("full_done_spacing_%0d", i), 32'(done_cyc[i] - done_cyc[i-1]), 32'(5));

    // Reset during STROBE with three commands still queued.
    mon_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      CmdValid = 1'b1; CmdOp = OP_DUTY; CmdChan = 5'(8 + i); CmdDuty = 10'(10'h200 + i);
      @(negedge clk);
    end
    CmdValid = 1'b0;
    w = 0;
    while (nLatch == 24'hFFFFFF && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("midrst_strobe_seen", 32'(nLatch), 32'(24'hFFFEFF));
    chk("midrst_busy_before", 32'(Busy), 32'(1));
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    chk("midrst_nlatch", 32'(nLatch), 32'(24'hFFFFFF));
    chk("midrst_ton", 32'(Ton), 32'(0));
    chk("midrst_oe", 32'(oe), 32'(0));
    chk("midrst_busy", 32'(Busy), 32'(0));
    chk("midrst_ready", 32'(CmdReady), 32'(1));
    evts = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (Done || Err || Busy || nLatch != 24'hFFFFFF) evts++;
    end
    chk("midrst_quiet_after", 32'(evts), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
